// File: rtl/rom_16x4.sv
// rom_16x4: 16-word x 4-bit constant lookup table with a registered, enable-gated read.
// Optional feature macro: ROM_PARITY_EN adds a registered parity output that tracks data.
// Words beyond the 16 defined entries read 0 when the address is wider than 4 bits.
// Wider words are zero-extended.
module rom_16x4 #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
`ifdef ROM_PARITY_EN
  ,
  output logic              parity
`endif
);

  // Address is widened to at least 4 bits so the table decode is always legal.
  localparam int AW = (ADDR_W > 4) ? ADDR_W : 4;

  logic [AW-1:0]     addr_ext;
  logic              in_tbl;
  logic [3:0]        word;
  logic [DATA_W-1:0] data_d, data_q;

  assign addr_ext = AW'(addr);

  // Any set bit above the low nibble selects an undefined entry, which reads 0.
  generate
    if (AW > 4) begin : g_hi
      assign in_tbl = (addr_ext[AW-1:4] == '0);
    end else begin : g_no_hi
      assign in_tbl = 1'b1;
    end
  endgenerate

  // Fixed table contents.
  always_comb begin
    word = 4'h0;
    if (in_tbl) begin
      case (addr_ext[3:0])
        4'h0: word = 4'h2;
        4'h1: word = 4'h4;
        4'h2: word = 4'h6;
        4'h3: word = 4'h8;
        4'h4: word = 4'hA;
        4'h5: word = 4'hC;
        4'h6: word = 4'hE;
        4'h7: word = 4'h1;
        4'h8: word = 4'h3;
        4'h9: word = 4'h5;
        4'hA: word = 4'h7;
        4'hB: word = 4'h9;
        4'hC: word = 4'hB;
        4'hD: word = 4'hD;
        4'hE: word = 4'hF;
        4'hF: word = 4'h0;
        default: word = 4'h0;
      endcase
    end
  end

  assign data_d = DATA_W'(word);

  // Output register: reset wins over enable; enable low holds the last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (en) begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

`ifdef ROM_PARITY_EN
  logic parity_d, parity_q;

  assign parity_d = ^word;

  // Parity register follows exactly the same reset/enable rules as data.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (en) begin
      parity_q <= parity_d;
    end
  end

  assign parity = parity_q;
`endif

endmodule

// File: tb/tb_rom_16x4.sv
// tb_rom_16x4: scoreboard bench for rom_16x4; a reference model pushes the expected
// registered word at drive time and each test pops and compares after the clock edge.
module tb_rom_16x4;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] addr;
  logic [3:0] data;
  logic       parity;

  rom_16x4 #(.ADDR_W(4), .DATA_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .addr   (addr),
    .data   (data)
`ifdef ROM_PARITY_EN
    ,
    .parity (parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] d;
    logic       p;
  } exp_t;

  logic [3:0] tbl [16] = '{4'h2, 4'h4, 4'h6, 4'h8, 4'hA, 4'hC, 4'hE, 4'h1,
                           4'h3, 4'h5, 4'h7, 4'h9, 4'hB, 4'hD, 4'hF, 4'h0};

  exp_t       sb [$];
  exp_t       e;
  logic [3:0] m_d;
  logic       m_p;
  int         checks = 0;
  int         passed = 0;

  // Drive one cycle of stimulus, push the model's expectation, then step past the edge.
  task automatic drive(input logic r, input logic n, input logic [3:0] a);
    rst  = r;
    en   = n;
    addr = a;
    if (r) begin
      m_d = 4'h0;
      m_p = 1'b0;
    end else if (n) begin
      m_d = tbl[a];
      m_p = ^tbl[a];
    end
    sb.push_back({m_d, m_p});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 4'hF);
      e = sb.pop_front();
      checks++;
      if (data !== e.d) $display("FAIL reset cyc%0d: data=%h expected %h", i, data, e.d);
      else passed++;
    end
  endtask

  task automatic test_first_read();
    logic       r_en   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] r_addr [4] = '{4'hF, 4'hF, 4'h2, 4'hA};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, r_en[i], r_addr[i]);
      e = sb.pop_front();
      checks++;
      if (data !== e.d) $display("FAIL first_read step%0d: data=%h expected %h", i, data, e.d);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 4'(i));
      e = sb.pop_front();
      checks++;
      if (data !== e.d) $display("FAIL sweep addr %0h: data=%h expected %h", i, data, e.d);
      else passed++;
`ifdef ROM_PARITY_EN
      checks++;
      if (parity !== e.p) $display("FAIL sweep_par addr %0h: parity=%b expected %b", i, parity, e.p);
      else passed++;
`endif
    end
  endtask

  task automatic test_hold();
    drive(1'b0, 1'b1, 4'h4);
    e = sb.pop_front();
    checks++;
    if (data !== e.d) $display("FAIL hold_load: data=%h expected %h", data, e.d);
    else passed++;
    // en low: address changes (including unknown) must not disturb the held word
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, (i == 3) ? 4'bxxxx : 4'h7);
      e = sb.pop_front();
      checks++;
      if (data !== e.d) $display("FAIL hold cyc%0d: data=%h expected %h", i, data, e.d);
      else passed++;
    end
    drive(1'b0, 1'b1, 4'h7);
    e = sb.pop_front();
    checks++;
    if (data !== e.d) $display("FAIL hold_release: data=%h expected %h", data, e.d);
    else passed++;
  endtask

  task automatic test_reset_midstream();
    logic r_rst [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(r_rst[i], 1'b1, 4'hE);
      e = sb.pop_front();
      checks++;
      if (data !== e.d) $display("FAIL mid_reset step%0d: data=%h expected %h", i, data, e.d);
      else passed++;
    end
  endtask

`ifdef ROM_PARITY_EN
  task automatic test_parity();
    logic [3:0] pa  [3] = '{4'h7, 4'h6, 4'h5};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, pa[i]);
      e = sb.pop_front();
      checks++;
      if (data !== e.d || parity !== e.p)
        $display("FAIL parity addr %0h: data=%h parity=%b expected %h %b", pa[i], data, parity, e.d, e.p);
      else passed++;
    end
    drive(1'b1, 1'b1, 4'h7);
    e = sb.pop_front();
    checks++;
    if (parity !== e.p || data !== e.d)
      $display("FAIL parity_reset: data=%h parity=%b expected %h %b", data, parity, e.d, e.p);
    else passed++;
  endtask
`endif

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    addr = 4'h0;
    m_d  = 4'h0;
    m_p  = 1'b0;
    test_reset();
    test_first_read();
    test_back_to_back();
    test_hold();
    test_reset_midstream();
`ifdef ROM_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
